reg_bank: RTL and testbench
===========================

# reg_bank

Parametrised register bank with a built-in write-select decoder, two registered read ports with write-forwarding, and a sequential clear engine. It generalises the fixed 3-to-8 write-enable decoder into a complete DEPTH x WIDTH register file for the register-file experiments. The bank takes one write and two reads per cycle, and can be wiped one entry per cycle on command.

## Interface
- WIDTH, 32, data width of each register (>= 1)
- DEPTH, 8, number of registers; power of two, >= 2
- AW, $clog2(DEPTH), select width; derived, never overridden
- ZERO_R0, 0, when 1 register 0 reads as zero and ignores writes
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write request
- wsel  in  AW  write register select
- wdata  in  WIDTH  write data
- rsel0  in  AW  read port 0 select
- rsel1  in  AW  read port 1 select
- rdata0  out  WIDTH  read port 0 data, registered
- rdata1  out  WIDTH  read port 1 data, registered
- clr  in  1  start sequential clear (sampled in IDLE only)
- busy  out  1  high while clear engine is in CLEAR
- wr_onehot  out  DEPTH  registered one-hot of the write accepted at the last edge
- wr_drop  out  1  registered pulse: a write request was rejected at the last edge

## Operation
- Reset (rst_n low, asynchronous): all registers 0, rdata0/rdata1 0, busy 0, wr_onehot 0, wr_drop 0, state IDLE, clear counter 0.
- Accepted write: we && state==IDLE && !(ZERO_R0 && wsel==0). On the edge: reg[wsel] <= wdata; wr_onehot <= 1<<wsel.
- Otherwise wr_onehot <= 0.
- wr_drop <= we && state==CLEAR.
- A write to r0 with ZERO_R0=1 is silently ignored: wr_drop 0, wr_onehot 0.
- Read port p, every edge:
  - rdata_p <= wdata if a write is accepted this cycle and wsel==rsel_p (forwarding).
  - Else rdata_p <= reg[rsel_p], pre-edge contents.
  - With ZERO_R0=1 and rsel_p==0, rdata_p <= 0.
  - Both ports may select the same register.
- FSM states:
  - IDLE: on clr, go to CLEAR with cnt <= 0.
  - CLEAR: each edge does reg[cnt] <= 0 and cnt <= cnt+1. At cnt==DEPTH-1, go to IDLE with cnt <= 0. clr is ignored in CLEAR.
- busy = (state==CLEAR), a direct decode of the state register.
- clr and we together in IDLE: the write is accepted at that edge, then the clear wipes it later.
- Reads during CLEAR are allowed. They return current contents: 0 for entries already cleared, old data for the rest. Forwarding never applies in CLEAR because no write is accepted.
- cnt wraps only via the DEPTH-1 -> IDLE transition and never exceeds DEPTH-1.
- Reset asserted mid-clear aborts the clear immediately; all registers end at 0 regardless.

## Timing
- Write-to-read latency: 1 cycle. Data written at edge k is readable from the array for the read at edge k+1. Forwarding makes it visible at edge k itself.
- Read latency: 1 cycle. rsel sampled at edge k appears on rdata after edge k.
- clr sampled high at edge k: busy is high from after edge k through edge k+DEPTH, i.e. exactly DEPTH cycles. reg[i] is zeroed at edge k+1+i.
- The first write accepted after a clear is at edge k+DEPTH+1.
- wr_onehot and wr_drop are single-cycle pulses per request and never high together.

## Test plan
- Reset, then write 0xDEADBEEF to r3 and read r3 next cycle -> rdata0=0xDEADBEEF, wr_onehot=8'b00001000 for one cycle.
- Write 0x12345678 to r5 with rsel0=rsel1=5 in the same cycle -> both rdata=0x12345678 after that edge (forwarding); old r5 value never appears.
- Fill r0..r7 with i+1 and pulse clr -> busy high exactly 8 cycles. Reading r7 during cycles 1-7 of CLEAR returns 8, and returns 0 after busy falls.
- we=1 throughout CLEAR -> wr_drop=1 each of those 8 cycles, no register changes, and no second clear from clr pulses during CLEAR.
- ZERO_R0=1, write 0xFFFFFFFF to r0 -> rdata0=0, wr_onehot=0, wr_drop=0.
- Assert rst_n low mid-clear at cnt=3 -> busy=0 and all outputs 0 immediately, without waiting for a clock edge; all registers read 0 afterwards.

Source files
------------

// File: rtl/reg_bank.sv
// DEPTH x WIDTH register file: one decoded write port, two registered read
// ports with same-cycle write forwarding, and a one-entry-per-cycle clear engine.
module reg_bank #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 8,
    parameter bit ZERO_R0 = 1'b0,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [AW-1:0]    wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    rsel0,
    input  logic [AW-1:0]    rsel1,
    output logic [WIDTH-1:0] rdata0,
    output logic [WIDTH-1:0] rdata1,
    input  logic             clr,
    output logic             busy,
    output logic [DEPTH-1:0] wr_onehot,
    output logic             wr_drop
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t            state, state_nxt;
    logic [AW-1:0]     cnt, cnt_nxt;
    logic [WIDTH-1:0]  regs [DEPTH];
    logic              wr_acc;

    assign wr_acc = we && (state == IDLE) && !(ZERO_R0 && (wsel == '0));
    assign busy   = (state == CLEAR);

    // Read value as seen at this edge: hardwired zero, forwarded write, or array.
    function automatic logic [WIDTH-1:0] read_val(input logic [AW-1:0] sel);
        if (ZERO_R0 && (sel == '0))
            return '0;
        else if (wr_acc && (wsel == sel))
            return wdata;
        else
            return regs[sel];
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == AW'(DEPTH - 1)) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                regs[i] <= '0;
        end else if (state == CLEAR) begin
            regs[cnt] <= '0;
        end else if (wr_acc) begin
            regs[wsel] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0    <= '0;
            rdata1    <= '0;
            wr_onehot <= '0;
            wr_drop   <= 1'b0;
        end else begin
            rdata0    <= read_val(rsel0);
            rdata1    <= read_val(rsel1);
            wr_onehot <= wr_acc ? (DEPTH'(1) << wsel) : '0;
            wr_drop   <= we && (state == CLEAR);
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Scoreboard bench for reg_bank: the driver queues hand-computed expectations,
// the monitor pops one per clock edge and compares both instances.
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  wsel = '0;
    logic [31:0] wdata = '0;
    logic [2:0]  rsel0 = '0;
    logic [2:0]  rsel1 = '0;
    logic        clr = 1'b0;

    logic [31:0] rdata0, rdata1, z_rdata0, z_rdata1;
    logic        busy, wr_drop, z_busy, z_wr_drop;
    logic [7:0]  wr_onehot, z_wr_onehot;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] rd0;
        logic [31:0] rd1;
        logic [7:0]  oh;
        logic        drop;
        logic        busy;
        bit          zchk;
        logic [31:0] zrd0;
        logic [7:0]  zoh;
        logic        zdrop;
    } exp_t;

    exp_t q[$];

    reg_bank #(.WIDTH(32), .DEPTH(8), .ZERO_R0(1'b0)) u_dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .wdata(wdata),
        .rsel0(rsel0), .rsel1(rsel1), .rdata0(rdata0), .rdata1(rdata1),
        .clr(clr), .busy(busy), .wr_onehot(wr_onehot), .wr_drop(wr_drop)
    );

    reg_bank #(.WIDTH(32), .DEPTH(8), .ZERO_R0(1'b1)) u_z (
        .clk(clk), .rst_n(rst_n), .we(we), .wsel(wsel), .wdata(wdata),
        .rsel0(rsel0), .rsel1(rsel1), .rdata0(z_rdata0), .rdata1(z_rdata1),
        .clr(clr), .busy(z_busy), .wr_onehot(z_wr_onehot), .wr_drop(z_wr_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic exp_t mk(input string n, input logic [31:0] a, input logic [31:0] b,
                                input logic [7:0] oh, input logic dr, input logic bs);
        exp_t e;
        e.name = n; e.rd0 = a; e.rd1 = b; e.oh = oh; e.drop = dr; e.busy = bs;
        e.zchk = 1'b0; e.zrd0 = '0; e.zoh = '0; e.zdrop = 1'b0;
        return e;
    endfunction

    task automatic cyc(input logic w, input logic [2:0] ws, input logic [31:0] wd,
                       input logic [2:0] r0, input logic [2:0] r1, input logic c, input exp_t e);
        @(negedge clk);
        we = w; wsel = ws; wdata = wd; rsel0 = r0; rsel1 = r1; clr = c;
        q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, ".rdata0"},    rdata0, 32'h0);
        chk({nm, ".rdata1"},    rdata1, 32'h0);
        chk({nm, ".busy"},      {31'h0, busy}, 32'h0);
        chk({nm, ".wr_onehot"}, {24'h0, wr_onehot}, 32'h0);
        chk({nm, ".wr_drop"},   {31'h0, wr_drop}, 32'h0);
        chk({nm, ".z_rdata0"},  z_rdata0, 32'h0);
        chk({nm, ".z_busy"},    {31'h0, z_busy}, 32'h0);
    endtask

    // Monitor: the read ports present a result after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk({e.name, ".rdata0"},    rdata0, e.rd0);
                chk({e.name, ".rdata1"},    rdata1, e.rd1);
                chk({e.name, ".wr_onehot"}, {24'h0, wr_onehot}, {24'h0, e.oh});
                chk({e.name, ".wr_drop"},   {31'h0, wr_drop}, {31'h0, e.drop});
                chk({e.name, ".busy"},      {31'h0, busy}, {31'h0, e.busy});
                if (e.zchk) begin
                    chk({e.name, ".z_rdata0"},    z_rdata0, e.zrd0);
                    chk({e.name, ".z_wr_onehot"}, {24'h0, z_wr_onehot}, {24'h0, e.zoh});
                    chk({e.name, ".z_wr_drop"},   {31'h0, z_wr_drop}, {31'h0, e.zdrop});
                end
            end
        end
    end

    initial begin
        exp_t e;
        #2;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write then read.
        cyc(1, 3'd3, 32'hDEADBEEF, 3'd0, 3'd1, 0, mk("wr_r3", 32'h0, 32'h0, 8'h08, 0, 0));
        cyc(0, 3'd0, 32'h0, 3'd3, 3'd3, 0, mk("rd_r3", 32'hDEADBEEF, 32'hDEADBEEF, 8'h00, 0, 0));

        // Forwarding: old r5 value must never appear.
        cyc(1, 3'd5, 32'hAAAA5555, 3'd3, 3'd0, 0, mk("wr_r5a", 32'hDEADBEEF, 32'h0, 8'h20, 0, 0));
        cyc(1, 3'd5, 32'h12345678, 3'd5, 3'd5, 0, mk("fwd_r5", 32'h12345678, 32'h12345678, 8'h20, 0, 0));
        cyc(0, 3'd0, 32'h0, 3'd5, 3'd3, 0, mk("rd_r5", 32'h12345678, 32'hDEADBEEF, 8'h00, 0, 0));

        // Fill r0..r7 with i+1; port 0 watches r7, port 1 the entry being written.
        for (int i = 0; i < 8; i++)
            cyc(1, 3'(i), 32'(i + 1), 3'd7, 3'(i), 0,
                mk($sformatf("fill%0d", i), (i == 7) ? 32'd8 : 32'd0, 32'(i + 1), 8'(1 << i), 0, 0));

        // Start clear.
        cyc(0, 3'd0, 32'h0, 3'd7, 3'd0, 1, mk("clr_start", 32'd8, 32'd1, 8'h00, 0, 1));

        // Writes and clr pulses throughout CLEAR are dropped / ignored.
        for (int j = 1; j <= 8; j++)
            cyc(1, 3'd7, 32'hCAFE0000, 3'd7, 3'd0, 1'(j % 2),
                mk($sformatf("clear%0d", j), 32'd8, (j == 1) ? 32'd1 : 32'd0, 8'h00, 1, (j < 8)));

        cyc(0, 3'd0, 32'h0, 3'd7, 3'd3, 0, mk("post_clr", 32'h0, 32'h0, 8'h00, 0, 0));
        for (int p = 0; p < 8; p += 2)
            cyc(0, 3'd0, 32'h0, 3'(p), 3'(p + 1), 0,
                mk($sformatf("zero_rd%0d", p), 32'h0, 32'h0, 8'h00, 0, 0));
        cyc(1, 3'd2, 32'h00000055, 3'd2, 3'd7, 0, mk("wr_after_clr", 32'h55, 32'h0, 8'h04, 0, 0));

        // ZERO_R0 instance ignores writes to r0; the plain instance accepts them.
        e = mk("wr_r0", 32'hFFFFFFFF, 32'h55, 8'h01, 0, 0);
        e.zchk = 1'b1; e.zrd0 = 32'h0; e.zoh = 8'h00; e.zdrop = 1'b0;
        cyc(1, 3'd0, 32'hFFFFFFFF, 3'd0, 3'd2, 0, e);
        e = mk("rd_r0", 32'hFFFFFFFF, 32'hFFFFFFFF, 8'h00, 0, 0);
        e.zchk = 1'b1;
        cyc(0, 3'd0, 32'h0, 3'd0, 3'd0, 0, e);

        // Reset mid-clear at cnt==3.
        cyc(1, 3'd6, 32'h00000066, 3'd0, 3'd6, 0, mk("wr_r6", 32'hFFFFFFFF, 32'h66, 8'h40, 0, 0));
        cyc(0, 3'd0, 32'h0, 3'd6, 3'd0, 1, mk("clr2_start", 32'h66, 32'hFFFFFFFF, 8'h00, 0, 1));
        for (int j = 1; j <= 3; j++)
            cyc(0, 3'd0, 32'h0, 3'd6, 3'd0, 0,
                mk($sformatf("clr2_%0d", j), 32'h66, (j == 1) ? 32'hFFFFFFFF : 32'h0, 8'h00, 0, 1));
        @(negedge clk);
        chk("pre_abort.busy", {31'h0, busy}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        for (int p = 0; p < 8; p += 2)
            cyc(0, 3'd0, 32'h0, 3'(p), 3'((p + 6) % 8), 0,
                mk($sformatf("after_abort%0d", p), 32'h0, 32'h0, 8'h00, 0, 0));

        repeat (4) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
